// File: rtl/bfp_decomp_sched.sv
// bfp_decomp_sched: round-robin packet scheduler sharing one BFP decompressor between NUM_CH sources.
// Optional feature macro: BFP_SCHED_RB_CHECK_EN enables the per-packet RB alignment check (status_err).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s_axis_*            per-channel compressed AXI-Stream inputs, channel i at slice i
//   ctrl_enable         channel may be granted
//   ctrl_width          per-channel mantissa width, 0 means 16
//   ctrl_credit_max     downstream buffer depth in beats, captured while rst is high
//   ctrl_err_clr        clears status_err
//   credit_ret          one downstream beat freed
//   din_*               registered beat to the decompressor (no backpressure)
//   status_busy/ch/err  transfer active, current/last granted channel, sticky RB errors
module bfp_decomp_sched #(
    parameter int  NUM_CH   = 4,
    parameter int  CREDIT_W = 6,
    localparam int CH_W     = $clog2(NUM_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CH*64-1:0]   s_axis_tdata,
    input  logic [NUM_CH-1:0]      s_axis_tvalid,
    input  logic [NUM_CH-1:0]      s_axis_tlast,
    input  logic [NUM_CH*32-1:0]   s_axis_tuser,
    output logic [NUM_CH-1:0]      s_axis_tready,
    input  logic [NUM_CH-1:0]      ctrl_enable,
    input  logic [NUM_CH*4-1:0]    ctrl_width,
    input  logic [CREDIT_W-1:0]    ctrl_credit_max,
    input  logic                   ctrl_err_clr,
    input  logic                   credit_ret,
    output logic [3:0]             din_width,
    output logic [63:0]            din_data,
    output logic                   din_valid,
    output logic                   din_last,
    output logic [31:0]            din_user,
    output logic                   status_busy,
    output logic [CH_W-1:0]        status_ch,
    output logic [NUM_CH-1:0]      status_err
);
    typedef enum logic {IDLE, XFER} state_t;
    state_t              state_q;
    logic [CH_W-1:0]     grant_q, rr_q, pick;
    logic [3:0]          width_q, dwidth_q;
    logic [CREDIT_W-1:0] credit_q, credit_d, cmax_q;
    logic [63:0]         data_q;
    logic [31:0]         user_q;
    logic [NUM_CH-1:0]   cand;
    logic                valid_q, last_q, pick_v, busy, can_go, acc, acc_last;

    assign busy          = (state_q == XFER);
    assign can_go        = busy && (credit_q != '0);
    assign acc           = can_go && s_axis_tvalid[grant_q];
    assign acc_last      = acc && s_axis_tlast[grant_q];
    assign cand          = ctrl_enable & s_axis_tvalid;
    assign s_axis_tready = can_go ? NUM_CH'(1) << grant_q : '0;
    // Return is ignored at the captured maximum so the counter saturates.
    assign credit_d = (acc && !credit_ret) ? credit_q - 1'b1 :
                      (!acc && credit_ret && credit_q != cmax_q) ? credit_q + 1'b1 : credit_q;

    // Scan downwards so the candidate closest after rr_q wins.
    always_comb begin
        pick_v = 1'b0;
        pick   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (cand[(int'(rr_q) + k) % NUM_CH]) begin
                pick_v = 1'b1;
                pick   = CH_W'((int'(rr_q) + k) % NUM_CH);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_q     <= '0;
            width_q  <= '0;
            credit_q <= ctrl_credit_max;
            cmax_q   <= ctrl_credit_max;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            data_q   <= '0;
            user_q   <= '0;
            dwidth_q <= '0;
        end else begin
            credit_q <= credit_d;
            valid_q  <= acc;
            last_q   <= acc_last;
            if (acc) begin
                data_q   <= s_axis_tdata[64*grant_q +: 64];
                user_q   <= {grant_q, s_axis_tuser[32*grant_q +: 32-CH_W]};
                dwidth_q <= width_q;
            end
            if (!busy && pick_v) begin
                state_q <= XFER;
                grant_q <= pick;
                width_q <= ctrl_width[4*pick +: 4];
            end else if (acc_last) begin
                state_q <= IDLE;
                rr_q    <= (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
            end
        end
    end

    assign din_valid   = valid_q;
    assign din_last    = last_q;
    assign din_data    = data_q;
    assign din_user    = user_q;
    assign din_width   = dwidth_q;
    assign status_busy = busy;
    assign status_ch   = grant_q;

`ifdef BFP_SCHED_RB_CHECK_EN
    // Beat index within the current RB; a packet must end on the 6th beat of an RB.
    logic [2:0]        beat_q;
    logic [NUM_CH-1:0] err_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q <= '0;
            err_q  <= '0;
        end else begin
            if (!busy) beat_q <= '0;
            else if (acc) beat_q <= (beat_q == 3'd5) ? 3'd0 : beat_q + 3'd1;
            err_q <= (err_q & ~{NUM_CH{ctrl_err_clr}}) |
                     ((acc_last && beat_q != 3'd5) ? NUM_CH'(1) << grant_q : '0);
        end
    end
    assign status_err = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = ctrl_err_clr;
    assign status_err     = '0;
`endif
endmodule

// File: doc/bfp_decomp_sched.md
# bfp_decomp_sched

Round-robin scheduler that shares one `bfp_decomp_exp` decompressor between `NUM_CH` compressed-IQ AXI-Stream sources. Grants whole packets (`tlast` to `tlast`) and latches the granted channel's bit width for the packet. It drives the decompressor's `din_*` port, which has no backpressure, so a credit counter returned from the downstream buffer throttles it. Sits between the per-antenna/per-eAxC ingress FIFOs and the shared decompressor.

## Interface
- `NUM_CH`, 4: number of requesters, 2..8; `CH_W = $clog2(NUM_CH)`.
- `CREDIT_W`, 6: credit counter width.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous and active-high.
- `s_axis_tdata` in `NUM_CH*64`: per-channel compressed beat; channel i occupies `[64*i +: 64]`.
- `s_axis_tvalid` in `NUM_CH`: per-channel valid.
- `s_axis_tlast` in `NUM_CH`: per-channel end of packet.
- `s_axis_tuser` in `NUM_CH*32`: per-channel user, 32 bits each.
- `s_axis_tready` out `NUM_CH`: per-channel ready.
- `ctrl_enable` in `NUM_CH`: channel may be granted.
- `ctrl_width` in `NUM_CH*4`: per-channel BFP mantissa width; 0 means 16.
- `ctrl_credit_max` in `CREDIT_W`: downstream buffer depth in beats; sampled while `rst` is high.
- `ctrl_err_clr` in 1: pulse that clears `status_err`.
- `credit_ret` in 1: one downstream beat freed.
- `din_width` out 4: to decompressor.
- `din_data` out 64: to decompressor.
- `din_valid` out 1: to decompressor.
- `din_last` out 1: to decompressor.
- `din_user` out 32: to decompressor.
- `status_busy` out 1: high in XFER.
- `status_ch` out `CH_W`: current or last granted channel.
- `status_err` out `NUM_CH`: sticky RB-alignment error per channel.

## Operation
- FSM states are IDLE and XFER.
- **IDLE**
  - Candidates are channels with `ctrl_enable[i] && s_axis_tvalid[i]`.
  - Pick the first candidate at or after `rr_ptr`, wrapping modulo `NUM_CH`.
  - Register `grant_ch`, latch `width_q = ctrl_width[grant_ch]` and go to XFER.
  - With no candidate, stay in IDLE.
- **XFER**
  - `s_axis_tready[grant_ch] = (credit != 0)`; all other `tready` bits are 0.
  - An accepted beat (`tvalid & tready`) is registered onto `din_*`:
    - `din_data` = tdata.
    - `din_last` = tlast.
    - `din_width` = `width_q`.
    - `din_user` = tuser with `[31:32-CH_W]` replaced by `grant_ch`.
  - An accepted beat with tlast sets `rr_ptr = grant_ch + 1` (mod `NUM_CH`) and returns to IDLE.
- The packet in progress always completes:
  - Dropping `ctrl_enable` mid-packet does not abort it.
  - Changing `ctrl_width` mid-packet has no effect; `width_q` holds.
- **Credit counter**
  - Loads `ctrl_credit_max` during reset.
  - Decrements by 1 per accepted beat and increments by 1 per `credit_ret`.
  - Both in the same cycle leaves it unchanged.
  - `credit_ret` when already at `ctrl_credit_max` is ignored; the counter saturates.
- `din_valid` is never high unless a credit was consumed for that beat.

## Timing
- Reset values:
  - `s_axis_tready` = 0.
  - `din_*` = 0, including `din_valid` and `din_last`.
  - `status_busy` = 0, `status_ch` = 0, `status_err` = 0.
  - State IDLE, `rr_ptr` = 0.
- Grant latency: candidate present in IDLE at cycle t gives `tready` high at t+1 (credit permitting).
- Data latency: beat accepted at t appears on `din_*` at t+1, for exactly one cycle.
- Back-to-back packets: exactly one bubble cycle (the IDLE arbitration cycle) between a tlast beat and the next packet's first beat.
- Credit exhausted: `tready` drops in the same cycle `credit` reaches 0 (combinational from registered credit). It resumes the cycle after the `credit_ret` increment is registered.
- Reset asserted mid-packet: next cycle the block is in reset state and `din_valid` is 0. The partial packet is abandoned, and the source must flush it.

## Configuration
- `BFP_SCHED_RB_CHECK_EN` defined:
  - A 3-bit beat counter per packet counts 0..5 and wraps to 0 (6 beats = 1 RB = 12 REs). It resets to 0 at grant.
  - An accepted tlast beat with counter != 5 sets `status_err[grant_ch]`. The beat is still forwarded.
  - `ctrl_err_clr` clears all bits. A set and a clear in the same cycle resolve to set.
- Not defined: no counter; `status_err` tied to 0.

## Test plan
- **Single channel:** ch1 sends 6 beats with tlast on the 6th, width 9, credit 32 -> 6 `din_valid` beats starting 2 cycles after first tvalid. `din_width` = 9, `din_user[31:30]` = 1, `din_last` on the 6th beat.
- **Round-robin:** all 4 channels continuously valid, 12-beat packets -> grant order 0,1,2,3,0. One bubble cycle between packets. No interleaving of beats within a packet.
- **Credit stall:** `ctrl_credit_max` = 4, no `credit_ret`, 12-beat packet -> exactly 4 beats, then `tready` = 0. One `credit_ret` pulse -> exactly one more beat. Simultaneous accept and return holds credit constant.
- **Mid-packet config change:** `ctrl_width[0]` changed 8 -> 12 and `ctrl_enable[0]` dropped at beat 3 -> remaining beats keep `din_width` = 8. The packet completes, then ch0 is no longer granted.
- **RB check (macro on):** 7-beat packet on ch2 -> `status_err` = 4'b0100 after tlast. `ctrl_err_clr` -> 0. A 12-beat packet raises no error.
- **Reset mid-packet:** `rst` asserted at beat 3 -> next cycle `din_valid` = 0, `tready` = 0, credit reloaded, next grant starts from ch0.
